// File: rtl/hs_arb_pkg.sv
// hs_ram_arbiter shared types.
// State encoding and counter widths.
package hs_arb_pkg;

  typedef enum logic [2:0] {
    ST_CPU,
    ST_WAIT_IDLE,
    ST_SETTLE,
    ST_HS,
    ST_RELEASE
  } state_t;

  localparam int TO_W = 16;
  localparam int ST_W = 4;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter: CPU vs hiscore engine.
// Pauses the CPU, waits for idle + settle, then grants.
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ext_pause,
  input  logic          cpu_idle,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  input  logic          hs_we,
  input  logic [DW-1:0] ram_dout,
  output logic          cpu_pause,
  output logic          hs_grant,
  output logic [DW-1:0] hs_dout,
  output logic          hs_timeout,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [ST_W-1:0] ST_END = ST_W'(SETTLE - 1);

  state_t          state;
  state_t          nxt;
  logic            arb_pause;
  logic            prev_hs;
  logic [TO_W-1:0] to_cnt;
  logic [ST_W-1:0] st_cnt;
  logic            to_hit;

  assign to_hit = hs_req && !cpu_idle && (to_cnt == TO_MAX);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_CPU;
      arb_pause  <= 1'b0;
      hs_grant   <= 1'b0;
      hs_timeout <= 1'b0;
      prev_hs    <= 1'b0;
      hs_dout    <= '0;
      to_cnt     <= '0;
      st_cnt     <= '0;
    end else begin
      state    <= nxt;
      hs_grant <= (nxt == ST_HS);
      prev_hs  <= (state == ST_HS);
      if (prev_hs)
        hs_dout <= ram_dout;
      unique case (state)
        ST_CPU: begin
          if (hs_req) begin
            arb_pause <= 1'b1;
            to_cnt    <= '0;
          end
        end
        ST_WAIT_IDLE: begin
          if (hs_req && cpu_idle)
            st_cnt <= '0;
          else if (to_hit)
            hs_timeout <= 1'b1;
          else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
        end
        ST_SETTLE: st_cnt <= st_cnt + 1'b1;
        ST_HS: ;
        ST_RELEASE: arb_pause <= 1'b0;
        default: arb_pause <= 1'b0;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_CPU:
        if (hs_req) nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE:
        if (!hs_req)      nxt = ST_RELEASE;
        else if (cpu_idle) nxt = ST_SETTLE;
        else if (to_hit)   nxt = ST_RELEASE;
      ST_SETTLE:
        if (!hs_req)             nxt = ST_RELEASE;
        else if (st_cnt >= ST_END) nxt = ST_HS;
      ST_HS:
        if (!hs_req) nxt = ST_RELEASE;
      ST_RELEASE: nxt = ST_CPU;
      default:    nxt = ST_CPU;
    endcase
  end

  // Writes are blocked while ownership is changing hands.
  always_comb begin
    cpu_pause = ext_pause | arb_pause;
    ram_addr  = cpu_addr;
    ram_din   = cpu_din;
    ram_we    = 1'b0;
    unique case (state)
      ST_CPU, ST_WAIT_IDLE: ram_we = cpu_we;
      ST_HS: begin
        ram_addr = hs_addr;
        ram_din  = hs_din;
        ram_we   = hs_we;
      end
      default: ram_we = 1'b0;
    endcase
    if (reset)
      ram_we = 1'b0;
  end

endmodule
